// File: rtl/mma_tile_sequencer_pkg.sv
// Shared definitions for the MMA tile sequencer: FSM encoding, shape decoding
// and the tile-count helper used when a run is captured.
package mma_tile_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  localparam int         SHAPE_BASE     = 4;
  localparam logic [3:0] MAX_SHAPE_CODE = 4'd7;
  localparam int         CNT_W          = 8;

  function automatic int shape_dim(input logic [3:0] code);
    logic [3:0] c;
    c = (code > MAX_SHAPE_CODE) ? MAX_SHAPE_CODE : code;
    return SHAPE_BASE << c;
  endfunction

  // A dimension smaller than the tile still needs one (partial) tile.
  function automatic logic [CNT_W-1:0] tile_count(input logic [3:0] code, input int tile);
    int n;
    n = shape_dim(code) / tile;
    if (n < 1) n = 1;
    return CNT_W'(n);
  endfunction

endpackage

// File: rtl/mma_tile_sequencer_loop_counter.sv
// Wrapping index counter; wrap_o flags the increment that returns idx to 0 so
// counters can be chained into a nested loop.
module mma_loop_counter
  import mma_tile_sequencer_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [IDX_W-1:0] limit_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             wrap_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  assign wrap_o = inc_i && (idx_q == limit_i);
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = wrap_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mma_tile_sequencer.sv
// Walks an MxNxK problem as tiles (k innermost, then n, then m), issuing one
// tile command per handshake while bounding issued-but-unretired tiles.
module mma_tile_sequencer
  import mma_tile_sequencer_pkg::*;
#(
  parameter int TILE_M          = 4,
  parameter int TILE_N          = 4,
  parameter int TILE_K          = 4,
  parameter int IDX_W           = 7,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             config_valid_i,
  input  logic [3:0]       shape_m_reg_i,
  input  logic [3:0]       shape_n_reg_i,
  input  logic [3:0]       shape_k_reg_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [IDX_W-1:0] tile_m_idx_o,
  output logic [IDX_W-1:0] tile_n_idx_o,
  output logic [IDX_W-1:0] tile_k_idx_o,
  output logic             tile_first_k_o,
  output logic             tile_last_k_o,
  input  logic             tile_retire_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             start_error_o,
  output logic             retire_error_o,
  output seq_state_e       state_o
);

  localparam int OUT_W = 4;

  // Tile handshake: a command transfers on a cycle where tile_valid_o and
  // tile_ready_i are both high. Once raised, tile_valid_o and every tile_*
  // field hold steady until that transfer (abort is the only early drop).
  seq_state_e       state_q;
  logic             valid_q, busy_q, done_q, aborted_q, start_err_q, retire_err_q;
  logic [IDX_W-1:0] lim_m_q, lim_n_q, lim_k_q;
  logic [OUT_W-1:0] out_q, out_d;

  logic             hs, ret_ok, ret_bad, accept, can_issue;
  logic             wrap_k, wrap_n, wrap_m;
  logic [IDX_W-1:0] idx_m, idx_n, idx_k;

  assign hs      = valid_q && tile_ready_i;
  assign ret_ok  = tile_retire_i && (out_q != '0);
  assign ret_bad = tile_retire_i && (out_q == '0);
  assign accept  = (state_q == SEQ_IDLE) && start_i && config_valid_i;

  always_comb begin
    out_d = out_q;
    if (hs && !ret_ok) begin
      out_d = out_q + OUT_W'(1);
    end else if (!hs && ret_ok) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  // Outstanding can only fall while a command waits, so valid never drops early.
  assign can_issue = (out_d < OUT_W'(MAX_OUTSTANDING));

  mma_loop_counter #(.IDX_W(IDX_W)) u_cnt_k (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .inc_i   (hs),
    .limit_i (lim_k_q),
    .idx_o   (idx_k),
    .wrap_o  (wrap_k)
  );

  mma_loop_counter #(.IDX_W(IDX_W)) u_cnt_n (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .inc_i   (wrap_k),
    .limit_i (lim_n_q),
    .idx_o   (idx_n),
    .wrap_o  (wrap_n)
  );

  mma_loop_counter #(.IDX_W(IDX_W)) u_cnt_m (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (accept),
    .inc_i   (wrap_n),
    .limit_i (lim_m_q),
    .idx_o   (idx_m),
    .wrap_o  (wrap_m)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= SEQ_IDLE;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      start_err_q  <= 1'b0;
      retire_err_q <= 1'b0;
      lim_m_q      <= '0;
      lim_n_q      <= '0;
      lim_k_q      <= '0;
      out_q        <= '0;
    end else begin
      out_q       <= out_d;
      start_err_q <= 1'b0;
      done_q      <= 1'b0;
      // A stray retire on the same cycle as an accepted start still flags.
      if (ret_bad) begin
        retire_err_q <= 1'b1;
      end else if (accept) begin
        retire_err_q <= 1'b0;
      end
      case (state_q)
        SEQ_IDLE: begin
          if (start_i) begin
            if (config_valid_i) begin
              lim_m_q   <= IDX_W'(tile_count(shape_m_reg_i, TILE_M) - 8'd1);
              lim_n_q   <= IDX_W'(tile_count(shape_n_reg_i, TILE_N) - 8'd1);
              lim_k_q   <= IDX_W'(tile_count(shape_k_reg_i, TILE_K) - 8'd1);
              aborted_q <= 1'b0;
              busy_q    <= 1'b1;
              valid_q   <= can_issue;
              state_q   <= SEQ_RUN;
            end else begin
              start_err_q <= 1'b1;
            end
          end
        end
        SEQ_RUN: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            valid_q   <= 1'b0;
            state_q   <= SEQ_DRAIN;
          end else if (wrap_m) begin
            valid_q <= 1'b0;
            state_q <= SEQ_DRAIN;
          end else begin
            valid_q <= can_issue;
          end
        end
        SEQ_DRAIN: begin
          if (out_q == '0) begin
            done_q  <= 1'b1;
            state_q <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          busy_q  <= 1'b0;
          state_q <= SEQ_IDLE;
        end
        default: begin
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign tile_valid_o   = valid_q;
  assign tile_m_idx_o   = idx_m;
  assign tile_n_idx_o   = idx_n;
  assign tile_k_idx_o   = idx_k;
  assign tile_first_k_o = valid_q && (idx_k == '0);
  assign tile_last_k_o  = valid_q && (idx_k == lim_k_q);
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign start_error_o  = start_err_q;
  assign retire_error_o = retire_err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_mma_tile_sequencer.sv
// Self-checking bench for mma_tile_sequencer: directed scenarios plus random
// runs compared every cycle against a tile-list reference model.
module tb_mma_tile_sequencer;
  import mma_tile_sequencer_pkg::*;

  localparam int IDX_W = 7;
  localparam int TILE  = 4;
  localparam int MAXO  = 2;
  localparam int TW    = 3 * IDX_W + 2;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort_in = 1'b0, cfg_valid = 1'b0;
  logic [3:0] sm = '0, sn = '0, sk = '0;
  logic ready = 1'b0, retire = 1'b0;
  logic valid, first_k, last_k, busy, done, aborted, serr, rerr;
  logic [IDX_W-1:0] tm, tn, tk;
  seq_state_e state;
  logic [TW-1:0] dut_tile;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mma_tile_sequencer #(
    .TILE_M(TILE), .TILE_N(TILE), .TILE_K(TILE), .IDX_W(IDX_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort_in), .config_valid_i(cfg_valid),
    .shape_m_reg_i(sm), .shape_n_reg_i(sn), .shape_k_reg_i(sk),
    .tile_valid_o(valid), .tile_ready_i(ready),
    .tile_m_idx_o(tm), .tile_n_idx_o(tn), .tile_k_idx_o(tk),
    .tile_first_k_o(first_k), .tile_last_k_o(last_k), .tile_retire_i(retire),
    .busy_o(busy), .done_o(done), .aborted_o(aborted),
    .start_error_o(serr), .retire_error_o(rerr), .state_o(state)
  );

  assign dut_tile = {tm, tn, tk, first_k, last_k};

  // scoreboard / reference model
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] hs_log[$];
  int  n_cmp = 0, n_fail = 0;
  int  ph = P_IDLE, md_out = 0;
  bit  md_abt = 0, md_rerr = 0, md_serr = 0;
  int  done_cnt = 0;
  bit  last_done_aborted = 0;
  bit  auto_rdy = 0, auto_ret = 0;
  int  rdy_pct = 100, ret_pct = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] pack(input int m, input int n, input int k, input bit f, input bit l);
    return {7'(m), 7'(n), 7'(k), f, l};
  endfunction

  function automatic int ntile(input int code);
    int n;
    n = (4 * (1 << code)) / TILE;
    return (n < 1) ? 1 : n;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; md_out = 0; md_abt = 0; md_rerr = 0; md_serr = 0;
    exp_q.delete();
  endtask

  task automatic build_list();
    int nm, nn, nk;
    nm = ntile(int'(sm)); nn = ntile(int'(sn)); nk = ntile(int'(sk));
    exp_q.delete();
    for (int m = 0; m < nm; m++)
      for (int n = 0; n < nn; n++)
        for (int k = 0; k < nk; k++)
          exp_q.push_back(pack(m, n, k, k == 0, k == nk - 1));
  endtask

  task automatic model_step();
    bit ev, hs, rok;
    if (rst) begin
      model_reset();
      return;
    end
    ev  = (ph == P_RUN) && (md_out < MAXO);
    hs  = ev && ready;
    rok = retire && (md_out > 0);
    md_serr = 0;
    if (ph == P_IDLE && start && cfg_valid) begin
      build_list();
      md_abt = 0; md_rerr = 0;
    end
    if (retire && md_out == 0) md_rerr = 1;
    case (ph)
      P_IDLE:  if (start) begin
                 if (cfg_valid) ph = P_RUN;
                 else md_serr = 1;
               end
      P_RUN:   begin
                 if (hs) void'(exp_q.pop_front());
                 if (abort_in) begin
                   md_abt = 1; ph = P_DRAIN;
                 end else if (hs && exp_q.size() == 0) begin
                   ph = P_DRAIN;
                 end
               end
      P_DRAIN: if (md_out == 0) ph = P_DONE;
      default: ph = P_IDLE;
    endcase
    md_out = md_out + int'(hs) - int'(rok);
  endtask

  task automatic check_all();
    bit ev;
    ev = (ph == P_RUN) && (md_out < MAXO);
    chk("tile_valid", valid, ev);
    chk("busy", busy, ph != P_IDLE);
    chk("state_busy", state != SEQ_IDLE, ph != P_IDLE);
    chk("done", done, ph == P_DONE);
    chk("aborted", aborted, md_abt);
    chk("start_error", serr, md_serr);
    chk("retire_error", rerr, md_rerr);
    if (ev && exp_q.size() > 0) chk("tile_fields", dut_tile, exp_q[0]);
    if (done) begin
      done_cnt++;
      last_done_aborted = aborted;
    end
  endtask

  // driver tasks
  task automatic tick();
    if (auto_rdy) ready = ($urandom_range(1, 100) <= rdy_pct);
    if (auto_ret) retire = (md_out > 0) && ($urandom_range(1, 100) <= ret_pct);
    if (valid && ready) hs_log.push_back(dut_tile);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic start_job(input int m, input int n, input int k, input bit cv);
    sm = 4'(m); sn = 4'(n); sk = 4'(k); cfg_valid = cv;
    hs_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input int abort_pct, input bit spurious);
    int budget;
    budget = 4000;
    while (ph != P_IDLE && budget > 0) begin
      abort_in = (abort_pct > 0) && ($urandom_range(1, 100) <= abort_pct);
      start = spurious && ($urandom_range(0, 19) == 0);
      if (start) begin
        sm = 4'($urandom_range(0, 2)); sn = 4'($urandom_range(0, 2)); sk = 4'($urandom_range(0, 2));
      end
      tick();
      budget--;
    end
    abort_in = 1'b0; start = 1'b0;
    if (budget == 0) chk("run_timeout", 1, 0);
  endtask

  task automatic wait_cond_k1();
    int budget;
    budget = 50;
    while (!(valid && tk == 7'd1) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("wait_tile_k1", 1, 0);
  endtask

  initial begin
    logic [TW-1:0] snap;
    int d0, budget;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_first_k", first_k, 0);
    chk("rst_last_k", last_k, 0);
    chk("rst_idx", {tm, tn, tk}, 0);
    rst = 1'b0;
    model_reset();
    tick();

    // single 4x4x4 tile
    auto_rdy = 1; rdy_pct = 100; auto_ret = 1; ret_pct = 100;
    d0 = done_cnt;
    start_job(0, 0, 0, 1);
    run_to_idle(0, 0);
    chk("s1_tiles", hs_log.size(), 1);
    if (hs_log.size() > 0) chk("s1_tile0", hs_log[0], pack(0, 0, 0, 1, 1));
    chk("s1_done_pulses", done_cnt - d0, 1);
    chk("s1_busy_end", busy, 0);

    // loop order m=1 n=0 k=2 -> 2x1x4 tiles
    start_job(1, 0, 2, 1);
    run_to_idle(0, 0);
    chk("s2_tiles", hs_log.size(), 8);
    for (int i = 0; i < 8 && i < hs_log.size(); i++)
      chk("s2_order", hs_log[i], pack(i / 4, 0, i % 4, (i % 4) == 0, (i % 4) == 3));

    // ready held low on tile (0,0,1)
    auto_rdy = 0; ready = 1'b1;
    start_job(0, 0, 2, 1);
    wait_cond_k1();
    ready = 1'b0;
    snap = dut_tile;
    chk("s3_snap", snap, pack(0, 0, 1, 0, 0));
    repeat (5) begin
      tick();
      chk("s3_hold_valid", valid, 1);
      chk("s3_hold_tile", dut_tile, snap);
    end
    ready = 1'b1;
    run_to_idle(0, 0);
    chk("s3_tiles", hs_log.size(), 4);

    // outstanding limit with retire withheld
    auto_ret = 0; retire = 1'b0;
    start_job(0, 0, 2, 1);
    repeat (6) tick();
    chk("s4_hs_at_limit", hs_log.size(), 2);
    chk("s4_valid_low", valid, 0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("s4_valid_again", valid, 1);
    chk("s4_third_k", tk, 2);
    auto_ret = 1;
    run_to_idle(0, 0);
    chk("s4_tiles", hs_log.size(), 4);

    // start errors, start while busy, retire while idle
    start_job(1, 1, 1, 0);
    chk("s5_start_error", serr, 1);
    chk("s5_busy_stays", busy, 0);
    tick();
    chk("s5_start_error_pulse", serr, 0);
    start_job(0, 0, 1, 1);
    tick();
    sm = 4'd2; sn = 4'd2; sk = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    run_to_idle(0, 0);
    chk("s5_busy_start_ignored", hs_log.size(), 2);
    auto_ret = 0; retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("s5_retire_error", rerr, 1);
    tick();
    chk("s5_retire_error_sticky", rerr, 1);

    // abort after 3 handshakes with 2 outstanding
    d0 = done_cnt;
    start_job(0, 0, 3, 1);
    budget = 20;
    while (hs_log.size() < 2 && budget > 0) begin tick(); budget--; end
    retire = 1'b1;
    tick();
    retire = 1'b0;
    tick();
    chk("s6_hs_before_abort", hs_log.size(), 3);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    repeat (3) tick();
    chk("s6_no_more_tiles", hs_log.size(), 3);
    chk("s6_no_done_yet", done_cnt - d0, 0);
    auto_ret = 1;
    run_to_idle(0, 0);
    chk("s6_done", done_cnt - d0, 1);
    chk("s6_done_aborted", last_done_aborted, 1);

    // reset mid-run
    auto_rdy = 1; rdy_pct = 60;
    start_job(1, 1, 1, 1);
    repeat (4) tick();
    chk("s7_running", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("s7_valid", valid, 0);
    chk("s7_busy", busy, 0);
    chk("s7_flags", {done, aborted, serr, rerr, first_k, last_k}, 0);
    chk("s7_idx", {tm, tn, tk}, 0);
    model_reset();
    auto_ret = 0; retire = 1'b0; auto_rdy = 0; ready = 1'b0;
    tick();
    rst = 1'b0;
    d0 = done_cnt;
    repeat (10) tick();
    chk("s7_no_done", done_cnt - d0, 0);

    // randomized runs
    auto_rdy = 1; auto_ret = 1;
    for (int j = 0; j < 40; j++) begin
      rdy_pct = $urandom_range(30, 100);
      ret_pct = $urandom_range(20, 100);
      start_job($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 9) != 0);
      run_to_idle(($urandom_range(0, 3) == 0) ? 2 : 0, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
